// File: rtl/interrupt_arbiter_if.sv
// rtl/interrupt_arbiter_if.sv - bus and interrupt handshake bundle for interrupt_arbiter
//
// Purpose: groups the processor bus control, peripheral request/ack lines
// and the CPU interrupt handshake of interrupt_arbiter.
//   BUS_ADDR      [7:0]  processor bus address
//   BUS_WE               1 = write, 0 = read
//   IRQ_IN        [3:0]  peripheral request lines, index 0 highest priority
//   IRQ_ACK_OUT   [3:0]  one-cycle acknowledge pulse to the serviced source
//   CPU_INT_RAISE        interrupt request to the processor
//   CPU_INT_ACK          processor acknowledge
//   bus_oe               high while the arbiter drives BUS_DATA
// The bidirectional BUS_DATA stays a plain port of the arbiter.
interface interrupt_arbiter_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [3:0] IRQ_IN;
  logic [3:0] IRQ_ACK_OUT;
  logic       CPU_INT_RAISE;
  logic       CPU_INT_ACK;
  logic       bus_oe;

  modport master (
    output BUS_ADDR, BUS_WE, IRQ_IN, CPU_INT_ACK,
    input  IRQ_ACK_OUT, CPU_INT_RAISE, bus_oe
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, IRQ_IN, CPU_INT_ACK,
    output IRQ_ACK_OUT, CPU_INT_RAISE, bus_oe
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - four-source fixed-priority interrupt arbiter with bus registers
//
// Purpose: latches rising edges of four request lines as pending bits,
// presents the highest-priority enabled one to the CPU, and pulses an
// acknowledge back to the source once the CPU acknowledges.
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   BUS_DATA   [7:0] bidirectional bus data, driven only the cycle after a read
//   bus        interrupt_arbiter_if.slave (address, write enable, irq lines,
//              CPU handshake, read output enable mirror)
// Registers (BASE_ADDR + offset):
//   +0 PENDING ro   +1 MASK rw   +2 CUR_ID ro {busy,5'b0,id}   +3 CLEAR wo
module interrupt_arbiter #(
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  interrupt_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] irq_prev;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [1:0] cur_id;
  logic       rd_oe;
  logic [7:0] rd_data;

  // Address decode relative to the register block; wraps modulo 256.
  logic [7:0] offset;
  logic       in_range;
  logic       wr_mask;
  logic       wr_clear;

  assign offset   = bus.BUS_ADDR - BASE_ADDR;
  assign in_range = (offset < 8'd4);
  assign wr_mask  = bus.BUS_WE && in_range && (offset[1:0] == 2'd1);
  assign wr_clear = bus.BUS_WE && in_range && (offset[1:0] == 2'd3);

  logic [3:0] rise;
  logic [3:0] clr_bits;
  logic [3:0] mask_nxt;
  logic [3:0] pending_pre;
  logic [3:0] cur_onehot;
  logic       live;
  logic       do_ack;
  logic [3:0] ack_bits;
  logic [3:0] pending_nxt;
  logic [3:0] req;
  logic [1:0] lowest;
  logic       busy;

  assign rise       = bus.IRQ_IN & ~irq_prev;
  assign clr_bits   = wr_clear ? BUS_DATA[3:0] : 4'b0000;
  assign mask_nxt   = wr_mask ? BUS_DATA[3:0] : mask;
  assign cur_onehot = 4'b0001 << cur_id;

  // The source in service stays live only if it will still be pending and
  // enabled after this edge; a same-edge CLEAR or MASK write withdraws it
  // immediately, while a same-edge rising request keeps it alive.
  assign pending_pre = (pending & ~clr_bits) | rise;
  assign live        = |(pending_pre & mask_nxt & cur_onehot);
  assign do_ack      = (state == RAISE) && live && bus.CPU_INT_ACK;
  assign ack_bits    = do_ack ? cur_onehot : 4'b0000;

  // Set wins over clear: rise is OR-ed in after both clear sources.
  assign pending_nxt = (pending & ~clr_bits & ~ack_bits) | rise;

  assign req  = pending & mask;
  assign busy = (state == RAISE) || (state == HOLD);

  always_comb begin
    lowest = 2'd0;
    if (req[0])      lowest = 2'd0;
    else if (req[1]) lowest = 2'd1;
    else if (req[2]) lowest = 2'd2;
    else if (req[3]) lowest = 2'd3;
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (offset[1:0])
      2'd0:    rd_mux = {4'h0, pending};
      2'd1:    rd_mux = {4'h0, mask};
      2'd2:    rd_mux = {busy, 5'b00000, cur_id};
      default: rd_mux = 8'h00;
    endcase
  end

  // Register state, request history and read pipeline.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_prev <= 4'h0;
      pending  <= 4'h0;
      mask     <= 4'hF;
      rd_oe    <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      irq_prev <= bus.IRQ_IN;
      pending  <= pending_nxt;
      mask     <= mask_nxt;
      rd_oe    <= !bus.BUS_WE && in_range;
      rd_data  <= rd_mux;
    end
  end

  // Service FSM with registered CPU request and source acknowledge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state             <= IDLE;
      cur_id            <= 2'd0;
      bus.CPU_INT_RAISE <= 1'b0;
      bus.IRQ_ACK_OUT   <= 4'h0;
    end else begin
      bus.IRQ_ACK_OUT <= ack_bits;
      case (state)
        IDLE: begin
          bus.CPU_INT_RAISE <= 1'b0;
          if (|req) begin
            cur_id            <= lowest;
            state             <= RAISE;
            bus.CPU_INT_RAISE <= 1'b1;
          end
        end
        RAISE: begin
          if (!live) begin
            state             <= IDLE;
            bus.CPU_INT_RAISE <= 1'b0;
          end else if (bus.CPU_INT_ACK) begin
            state             <= HOLD;
            bus.CPU_INT_RAISE <= 1'b0;
          end
        end
        HOLD: begin
          // Guarantees a low cycle on CPU_INT_RAISE between services.
          state             <= IDLE;
          bus.CPU_INT_RAISE <= 1'b0;
        end
        default: begin
          state             <= IDLE;
          bus.CPU_INT_RAISE <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_oe = rd_oe;
  assign BUS_DATA   = rd_oe ? rd_data : 8'hzz;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - directed vector bench for interrupt_arbiter
module tb_interrupt_arbiter;

  typedef struct {
    logic [3:0] irq;
    logic       ack;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       e_raise;
    logic [3:0] e_ack;
    logic       e_oe;
    logic [7:0] e_rd;
  } vec_t;

  localparam logic [7:0] NA = 8'h00;

  logic       clk;
  logic       rst;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int total;
  int bad;

  interrupt_arbiter_if intf ();

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  interrupt_arbiter #(.BASE_ADDR(8'hE0)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .BUS_DATA (bus_data),
    .bus      (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] irq, input logic ack, input logic we,
                              input logic [7:0] addr, input logic [7:0] wd,
                              input logic e_raise, input logic [3:0] e_ack,
                              input logic e_oe, input logic [7:0] e_rd);
    vec_t v;
    v.irq = irq; v.ack = ack; v.we = we; v.addr = addr; v.wd = wd;
    v.e_raise = e_raise; v.e_ack = e_ack; v.e_oe = e_oe; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    intf.IRQ_IN      = v.irq;
    intf.CPU_INT_ACK = v.ack;
    intf.BUS_WE      = v.we;
    intf.BUS_ADDR    = v.addr;
    tb_drv           = v.we;
    tb_wdata         = v.wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " raise"}, {7'd0, intf.CPU_INT_RAISE}, {7'd0, v.e_raise});
    chk({tag, " ack"}, {4'd0, intf.IRQ_ACK_OUT}, {4'd0, v.e_ack});
    chk({tag, " oe"}, {7'd0, intf.bus_oe}, {7'd0, v.e_oe});
    if (v.e_oe) chk({tag, " rdata"}, bus_data, v.e_rd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    intf.IRQ_IN = 4'h0; intf.CPU_INT_ACK = 1'b0; intf.BUS_WE = 1'b0; intf.BUS_ADDR = NA;
    tb_drv = 1'b0; tb_wdata = 8'h00;

    // Reset registers, read-back of reset values, CLEAR reads as zero.
    vecs.push_back(mk(4'b0000,0,0,8'hE1,8'h00, 0,4'b0000,1,8'h0F));
    vecs.push_back(mk(4'b0000,0,0,8'hE2,8'h00, 0,4'b0000,1,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    vecs.push_back(mk(4'b0000,0,1,8'hE3,8'hFF, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE3,8'h00, 0,4'b0000,1,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE4,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hDF,8'h00, 0,4'b0000,0,8'h00));
    // Single source 2.
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,1,0,NA,8'h00, 0,4'b0100,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // Priority 1 then 3, CUR_ID reads during service.
    vecs.push_back(mk(4'b1010,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1010,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1010,0,0,8'hE2,8'h00, 1,4'b0000,1,8'h81));
    vecs.push_back(mk(4'b1010,1,0,NA,8'h00, 0,4'b0010,0,8'h00));
    vecs.push_back(mk(4'b1010,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1010,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1010,0,0,8'hE2,8'h00, 1,4'b0000,1,8'h83));
    vecs.push_back(mk(4'b1010,1,0,NA,8'h00, 0,4'b1000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // Masking source 0.
    vecs.push_back(mk(4'b0000,0,1,8'hE1,8'h0E, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0001,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h01));
    vecs.push_back(mk(4'b0000,0,0,8'hE1,8'h00, 0,4'b0000,1,8'h0E));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,1,8'hE1,8'h0F, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,1,0,NA,8'h00, 0,4'b0001,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // Withdrawal by CLEAR of source 1.
    vecs.push_back(mk(4'b0010,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0010,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0010,0,1,8'hE3,8'h02, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // Withdrawal by MASK of source 2, then re-enable.
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,0,1,8'hE1,8'h0B, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h04));
    vecs.push_back(mk(4'b0000,0,1,8'hE1,8'h0F, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,1,0,NA,8'h00, 0,4'b0100,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // CPU ack ignored in IDLE and HOLD.
    vecs.push_back(mk(4'b0000,1,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0001,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0001,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0001,1,0,NA,8'h00, 0,4'b0001,0,8'h00));
    vecs.push_back(mk(4'b0001,1,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,1,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    // Set beats CLEAR on the same edge.
    vecs.push_back(mk(4'b1000,0,1,8'hE3,8'h08, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1000,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b1000,1,0,NA,8'h00, 0,4'b1000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    // Set beats ack on the same edge: source 2 is served twice.
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,1,0,NA,8'h00, 0,4'b0100,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0100,0,0,8'hE2,8'h00, 1,4'b0000,1,8'h82));
    vecs.push_back(mk(4'b0100,1,0,NA,8'h00, 0,4'b0100,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    // No preemption: source 0 arrives while 2 is raised.
    vecs.push_back(mk(4'b0100,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0101,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0101,0,0,8'hE2,8'h00, 1,4'b0000,1,8'h82));
    vecs.push_back(mk(4'b0101,1,0,NA,8'h00, 0,4'b0100,0,8'h00));
    vecs.push_back(mk(4'b0101,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0101,0,0,NA,8'h00, 1,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0101,0,0,8'hE2,8'h00, 1,4'b0000,1,8'h80));
    vecs.push_back(mk(4'b0101,1,0,NA,8'h00, 0,4'b0001,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    vecs.push_back(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));

    #1;
    chk("reset raise", {7'd0, intf.CPU_INT_RAISE}, 8'h00);
    chk("reset ack", {4'd0, intf.IRQ_ACK_OUT}, 8'h00);
    chk("reset oe", {7'd0, intf.bus_oe}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the middle of a service.
    step(mk(4'b0001,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    step(mk(4'b0001,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    chk("mid raise before reset", {7'd0, intf.CPU_INT_RAISE}, 8'h01);
    intf.IRQ_IN = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("mid reset raise async", {7'd0, intf.CPU_INT_RAISE}, 8'h00);
    chk("mid reset ack", {4'd0, intf.IRQ_ACK_OUT}, 8'h00);
    chk("mid reset oe", {7'd0, intf.bus_oe}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    check_vec("post reset pending", mk(4'b0000,0,0,8'hE0,8'h00, 0,4'b0000,1,8'h00));
    step(mk(4'b0000,0,0,8'hE1,8'h00, 0,4'b0000,1,8'h0F));
    check_vec("post reset mask", mk(4'b0000,0,0,8'hE1,8'h00, 0,4'b0000,1,8'h0F));
    step(mk(4'b0000,0,0,8'hE2,8'h00, 0,4'b0000,1,8'h00));
    check_vec("post reset cur_id", mk(4'b0000,0,0,8'hE2,8'h00, 0,4'b0000,1,8'h00));
    step(mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));
    check_vec("post reset idle", mk(4'b0000,0,0,NA,8'h00, 0,4'b0000,0,8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hE0, bus address of the first of four registers (BASE_ADDR..BASE_ADDR+3).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port BUS_ADDR  input  8  processor bus address.
REQ-005 SHALL have port BUS_DATA  inout  8  processor bus data; high-Z unless this block is returning read data.
REQ-006 SHALL have port BUS_WE  input  1  bus write enable; 1 = write, 0 = read.
REQ-007 SHALL have port IRQ_IN  input  4  interrupt request lines from peripherals; index 0 has the highest priority.
REQ-008 SHALL have port IRQ_ACK_OUT  output  4  one-cycle acknowledge pulse back to the serviced source.
REQ-009 SHALL have port CPU_INT_RAISE  output  1  interrupt request to the processor.
REQ-010 SHALL have port CPU_INT_ACK  input  1  processor acknowledge for CPU_INT_RAISE.

Function
REQ-011 SHALL set pending[i] on a rising edge of IRQ_IN[i], detected against a registered copy of IRQ_IN; a held level SHALL NOT re-set pending.
REQ-012 SHALL provide registers at the following offsets:
- +0 PENDING: read-only; bits[3:0] = pending, bits[7:4] = 0.
- +1 MASK: read/write; bits[3:0] = enable, bits[7:4] read 0.
- +2 CUR_ID: read-only; bit7 = busy, bits[1:0] = index in service.
- +3 CLEAR: write-only; a 1 in bits[3:0] clears the corresponding pending bit.
REQ-013 SHALL accept a write on the clock edge where BUS_WE=1 and BUS_ADDR matches the register offset.
REQ-014 SHALL return read data one cycle after the address:
- On the edge where BUS_WE=0 and BUS_ADDR is in range, it registers the data and the output enable.
- BUS_DATA is driven for exactly the following cycle, otherwise Z.
- Reads of +3 return 8'h00.
REQ-015 SHALL implement states IDLE, RAISE and HOLD.
REQ-016 SHALL, in IDLE, when (pending & MASK[3:0]) is nonzero, latch cur_id = lowest set index and go to RAISE; CPU_INT_RAISE=0 in IDLE.
REQ-017 SHALL, in RAISE, assert CPU_INT_RAISE=1.
REQ-018 SHALL, in RAISE, on the edge where CPU_INT_ACK=1, do all of the following:
- clear pending[cur_id];
- pulse IRQ_ACK_OUT[cur_id]=1 for exactly one cycle;
- deassert CPU_INT_RAISE;
- enter HOLD.
REQ-019 SHALL spend exactly one cycle in HOLD, then return to IDLE, guaranteeing at least one low cycle of CPU_INT_RAISE between services.
REQ-020 SHALL, in RAISE, return to IDLE without an ack pulse if pending[cur_id] is cleared by a CLEAR write or MASK[cur_id] becomes 0.
REQ-021 SHALL keep cur_id fixed while in RAISE; a higher-priority request arriving meanwhile is served after HOLD (no preemption).
REQ-022 SHALL resolve a rising-edge set and a clear (CLEAR write or ack) of the same bit on the same edge in favour of the set.
REQ-023 SHALL ignore CPU_INT_ACK outside RAISE.
REQ-024 SHALL assert busy (CUR_ID bit7) in RAISE and HOLD only.

Reset
REQ-025 SHALL, while RESET=1, force the following values; RESET deassertion mid-service restarts in IDLE with no ack pulse:
- state = IDLE; pending = 0; MASK = 4'hF;
- cur_id = 0; IRQ_IN history = 0;
- CPU_INT_RAISE = 0; IRQ_ACK_OUT = 0;
- read output enable = 0, so BUS_DATA = Z.

Verification
REQ-026 SHALL cover single source: IRQ_IN[2] 0->1, CPU_INT_ACK one cycle later; required response:
- CPU_INT_RAISE=1 two cycles after the edge;
- IRQ_ACK_OUT=4'b0100 for one cycle after the ack;
- PENDING reads 8'h00.
REQ-027 SHALL cover priority: IRQ_IN 4'b1010 rising together; required response:
- first service cur_id=1 with IRQ_ACK_OUT=4'b0010;
- then, after HOLD, cur_id=3 with IRQ_ACK_OUT=4'b1000.
REQ-028 SHALL cover masking: write MASK=8'h0E, pulse IRQ_IN[0]; required response:
- PENDING=8'h01 and CPU_INT_RAISE stays 0;
- after writing MASK=8'h0F, raise follows.
REQ-029 SHALL cover withdrawal: in RAISE for source 1, write CLEAR=8'h02; required response: CPU_INT_RAISE=0 next cycle, IRQ_ACK_OUT stays 0.
REQ-030 SHALL cover bus reads: read BASE_ADDR+2 during service of source 3; required response: BUS_DATA=8'h83 in the next cycle only, Z before and after.
REQ-031 SHALL cover reset mid-service: RESET asserted in RAISE; required response:
- CPU_INT_RAISE=0 asynchronously;
- PENDING=8'h00 and MASK=8'h0F after release.
